multisim_quasi_static_push_mux: RTL and testbench

MULTISIM_QUASI_STATIC_PUSH_MUX -- requirements
Module: multisim_quasi_static_push_mux

---
 rtl/multisim_quasi_static_pkg.sv | 15 +
 rtl/multisim_rr_arbiter.sv | 30 +++
 rtl/multisim_quasi_static_push_mux.sv | 110 +++++++++++
 tb/tb_multisim_quasi_static_push_mux.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multisim_quasi_static_pkg.sv
// Shared types and helpers for the quasi-static push mux.
package multisim_quasi_static_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } mux_state_e;

  // $clog2 clamped to at least one bit so single-entry indices stay legal.
  function automatic int clog2_min1(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multisim_rr_arbiter.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
import multisim_quasi_static_pkg::*;

module multisim_rr_arbiter #(
  parameter  int N = 4,
  localparam int W = clog2_min1(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx
);

  logic [W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = N; k >= 1; k--) begin
      idx = W'((int'(last) + k) % N);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/multisim_quasi_static_push_mux.sv
// Pushes changed (or force-flagged) quasi-static channel values onto one
// valid/ready transport, round-robin, with an optional idle gap per transfer.
import multisim_quasi_static_pkg::*;

module multisim_quasi_static_push_mux #(
  parameter  int NUM_CHANNELS = 4,
  parameter  int DATA_WIDTH   = 32,
  parameter  int MIN_GAP      = 0,
  localparam int CH_W         = clog2_min1(NUM_CHANNELS)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] ch_data,
  input  logic [NUM_CHANNELS-1:0]                ch_force,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [CH_W-1:0]                        out_channel,
  output logic [DATA_WIDTH-1:0]                  out_data,
  output logic [NUM_CHANNELS-1:0]                pending,
  output logic [31:0]                            tx_count
);

  localparam int              GAP_W   = clog2_min1(MIN_GAP + 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);

  mux_state_e                              state;
  logic [GAP_W-1:0]                        gap_cnt;
  logic [CH_W-1:0]                         rr_last;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] last_sent;
  logic [NUM_CHANNELS-1:0]                 force_bit;
  logic                                    gnt_valid;
  logic [CH_W-1:0]                         gnt_idx;
  logic                                    hs;
  logic                                    grant_now;

  assign out_valid = (state == SEND);
  assign hs        = out_valid & out_ready;

  // The last gap cycle grants directly so the idle stretch is exactly MIN_GAP.
  assign grant_now = gnt_valid &
                     ((state == IDLE) | ((state == GAP) & (gap_cnt == '0)));

  always_comb begin
    pending = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      pending[i] = (ch_data[i] != last_sent[i]) | force_bit[i];
  end

  multisim_rr_arbiter #(.N(NUM_CHANNELS)) u_arb (
    .req       (pending),
    .last      (rr_last),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Force bits come up set so every channel is synced once after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_sent <= '0;
      force_bit <= '1;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (hs && out_channel == CH_W'(i)) begin
          last_sent[i] <= out_data;
          force_bit[i] <= ch_force[i];
        end else if (ch_force[i]) begin
          force_bit[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      rr_last     <= LAST_CH;
      out_channel <= '0;
      out_data    <= '0;
      tx_count    <= '0;
    end else begin
      case (state)
        IDLE: ;
        SEND: begin
          if (out_ready) begin
            tx_count <= tx_count + 32'd1;
            if (MIN_GAP > 0) begin
              state   <= GAP;
              gap_cnt <= GAP_W'(MIN_GAP - 1);
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
          else               state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (grant_now) begin
        state       <= SEND;
        out_channel <= gnt_idx;
        out_data    <= ch_data[gnt_idx];
        rr_last     <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_multisim_quasi_static_push_mux.sv
// Scenario bench for the quasi-static push mux: one DUT with no gap, one with MIN_GAP=3.
module tb_multisim_quasi_static_push_mux;

  localparam int NC = 4;
  localparam int DW = 32;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NC-1:0][DW-1:0] ch_data, ch_data_b;
  logic [NC-1:0]         ch_force, ch_force_b, pending, pending_b;
  logic                  out_valid, out_ready, out_valid_b, out_ready_b;
  logic [CW-1:0]         out_channel, out_channel_b;
  logic [DW-1:0]         out_data, out_data_b;
  logic [31:0]           tx_count, tx_count_b;

  int n_tests = 0;
  int n_fail  = 0;
  logic [CW+DW-1:0] sb_q[$];
  logic [CW+DW-1:0] exp_x;

  multisim_quasi_static_push_mux #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW), .MIN_GAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .ch_force(ch_force),
    .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel),
    .out_data(out_data), .pending(pending), .tx_count(tx_count)
  );

  multisim_quasi_static_push_mux #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW), .MIN_GAP(3)) dut_gap (
    .clk(clk), .rst_n(rst_n), .ch_data(ch_data_b), .ch_force(ch_force_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_channel(out_channel_b),
    .out_data(out_data_b), .pending(pending_b), .tx_count(tx_count_b)
  );

  task automatic test_reset();
    rst_n = 1'b0; ch_data = '0; ch_data_b = '0; ch_force = '0; ch_force_b = '0;
    out_ready = 1'b1; out_ready_b = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({out_valid, out_channel, out_data, tx_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%0b ch=%0d data=0x%08h cnt=%0d, want all 0",
               out_valid, out_channel, out_data, tx_count);
    end
    n_tests++;
    if (pending !== 4'hF) begin
      n_fail++; $display("FAIL reset_pending: got %b want 1111", pending);
    end
    rst_n = 1'b1;
    for (int i = 0; i < NC; i++) sb_q.push_back({CW'(i), 32'h0});
    for (int c = 0; c < 64 && sb_q.size() > 0; c++) begin
      if (out_valid && out_ready) begin
        exp_x = sb_q.pop_front(); n_tests++;
        if ({out_channel, out_data} !== exp_x) begin
          n_fail++;
          $display("FAIL reset_sync_xfer: got ch%0d 0x%08h want ch%0d 0x%08h",
                   out_channel, out_data, exp_x[DW+:CW], exp_x[DW-1:0]);
        end
      end
      @(negedge clk); ch_force = '0;
    end
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL reset_sync_timeout: %0d transfers missing, want 0", sb_q.size());
      sb_q.delete();
    end
    n_tests++;
    if (tx_count !== 32'd4 || pending !== 4'h0) begin
      n_fail++; $display("FAIL reset_sync_done: cnt=%0d pending=%b want 4 / 0000", tx_count, pending);
    end
  endtask

  task automatic test_latency();
    repeat (2) @(negedge clk);
    ch_data[2] = 32'hDEADBEEF;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || pending[2] !== 1'b1) begin
      n_fail++; $display("FAIL latency_pre: valid=%0b pending2=%0b want 0/1", out_valid, pending[2]);
    end
    @(negedge clk);
    n_tests++;
    if ({out_valid, out_channel, out_data} !== {1'b1, 2'd2, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL latency_offer: valid=%0b ch%0d 0x%08h want 1 ch2 0xdeadbeef",
               out_valid, out_channel, out_data);
    end
    @(negedge clk);
    n_tests++;
    if (pending[2] !== 1'b0 || tx_count !== 32'd5) begin
      n_fail++; $display("FAIL latency_done: pending2=%0b cnt=%0d want 0/5", pending[2], tx_count);
    end
  endtask

  task automatic test_coalesce();
    out_ready = 1'b0;
    ch_data[1] = 32'd5;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) ch_data[1] = 32'd6;
      if (k == 6) ch_data[1] = 32'd7;
      @(negedge clk);
      n_tests++;
      if ({out_valid, out_channel, out_data} !== {1'b1, 2'd1, 32'd5}) begin
        n_fail++;
        $display("FAIL coalesce_hold: valid=%0b ch%0d data=%0d want 1 ch1 5",
                 out_valid, out_channel, out_data);
      end
    end
    sb_q.push_back({2'd1, 32'd5});
    sb_q.push_back({2'd1, 32'd7});
    out_ready = 1'b1;
    for (int c = 0; c < 64 && sb_q.size() > 0; c++) begin
      if (out_valid && out_ready) begin
        exp_x = sb_q.pop_front(); n_tests++;
        if ({out_channel, out_data} !== exp_x) begin
          n_fail++;
          $display("FAIL coalesce_xfer: got ch%0d 0x%08h want ch%0d 0x%08h",
                   out_channel, out_data, exp_x[DW+:CW], exp_x[DW-1:0]);
        end
      end
      @(negedge clk); ch_force = '0;
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if (sb_q.size() != 0 || tx_count !== 32'd7 || pending !== 4'h0) begin
      n_fail++;
      $display("FAIL coalesce_count: left=%0d cnt=%0d pending=%b want 0/7/0000",
               sb_q.size(), tx_count, pending);
      sb_q.delete();
    end
  endtask

  task automatic test_rr_order();
    // A forced resend of channel 0 also leaves the round-robin pointer at 0.
    ch_force[0] = 1'b1;
    sb_q.push_back({2'd0, 32'h0});
    for (int c = 0; c < 64 && sb_q.size() > 0; c++) begin
      if (out_valid && out_ready) begin
        exp_x = sb_q.pop_front(); n_tests++;
        if ({out_channel, out_data} !== exp_x) begin
          n_fail++;
          $display("FAIL force_xfer: got ch%0d 0x%08h want ch%0d 0x%08h",
                   out_channel, out_data, exp_x[DW+:CW], exp_x[DW-1:0]);
        end
      end
      @(negedge clk); ch_force = '0;
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (sb_q.size() != 0 || tx_count !== 32'd8) begin
      n_fail++; $display("FAIL force_once: left=%0d cnt=%0d want 0/8", sb_q.size(), tx_count);
      sb_q.delete();
    end
    ch_data[0] = 32'hA1;
    ch_data[3] = 32'hA3;
    sb_q.push_back({2'd3, 32'hA3});
    sb_q.push_back({2'd0, 32'hA1});
    for (int c = 0; c < 64 && sb_q.size() > 0; c++) begin
      if (out_valid && out_ready) begin
        exp_x = sb_q.pop_front(); n_tests++;
        if ({out_channel, out_data} !== exp_x) begin
          n_fail++;
          $display("FAIL rr_order_xfer: got ch%0d 0x%08h want ch%0d 0x%08h",
                   out_channel, out_data, exp_x[DW+:CW], exp_x[DW-1:0]);
        end
      end
      @(negedge clk); ch_force = '0;
    end
    n_tests++;
    if (sb_q.size() != 0 || tx_count !== 32'd10) begin
      n_fail++; $display("FAIL rr_order_count: left=%0d cnt=%0d want 0/10", sb_q.size(), tx_count);
      sb_q.delete();
    end
  endtask

  task automatic test_force_on_handshake();
    out_ready = 1'b0;
    ch_force[2] = 1'b1;
    @(negedge clk); ch_force = '0;
    for (int c = 0; c < 8 && !out_valid; c++) @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || out_channel !== 2'd2) begin
      n_fail++; $display("FAIL force_hs_offer: valid=%0b ch%0d want 1 ch2", out_valid, out_channel);
    end
    out_ready = 1'b1;
    ch_force[2] = 1'b1;
    sb_q.push_back({2'd2, 32'hDEADBEEF});
    sb_q.push_back({2'd2, 32'hDEADBEEF});
    for (int c = 0; c < 64 && sb_q.size() > 0; c++) begin
      if (out_valid && out_ready) begin
        exp_x = sb_q.pop_front(); n_tests++;
        if ({out_channel, out_data} !== exp_x) begin
          n_fail++;
          $display("FAIL force_hs_xfer: got ch%0d 0x%08h want ch%0d 0x%08h",
                   out_channel, out_data, exp_x[DW+:CW], exp_x[DW-1:0]);
        end
      end
      @(negedge clk); ch_force = '0;
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (sb_q.size() != 0 || tx_count !== 32'd12) begin
      n_fail++; $display("FAIL force_hs_count: left=%0d cnt=%0d want 0/12", sb_q.size(), tx_count);
      sb_q.delete();
    end
  endtask

  task automatic test_gap();
    int hs_seen;
    int low;
    int gap_low;
    hs_seen = 0; low = 0; gap_low = -1;
    n_tests++;
    if (tx_count_b !== 32'd4) begin
      n_fail++; $display("FAIL gap_sync: cnt=%0d want 4", tx_count_b);
    end
    ch_data_b[1] = 32'd11;
    ch_data_b[2] = 32'd22;
    sb_q.push_back({2'd1, 32'd11});
    sb_q.push_back({2'd2, 32'd22});
    for (int c = 0; c < 60 && hs_seen < 2; c++) begin
      @(negedge clk);
      if (out_valid_b && out_ready_b) begin
        exp_x = sb_q.pop_front(); n_tests++;
        if ({out_channel_b, out_data_b} !== exp_x) begin
          n_fail++;
          $display("FAIL gap_xfer: got ch%0d 0x%08h want ch%0d 0x%08h",
                   out_channel_b, out_data_b, exp_x[DW+:CW], exp_x[DW-1:0]);
        end
        hs_seen++;
        if (hs_seen == 2) gap_low = low;
        low = 0;
      end else begin
        low++;
      end
    end
    n_tests++;
    if (gap_low != 3) begin
      n_fail++; $display("FAIL gap_idle_cycles: got %0d want 3 (handshakes seen %0d)", gap_low, hs_seen);
    end
    sb_q.delete();
  endtask

  task automatic test_reset_mid_send();
    out_ready = 1'b0;
    ch_data[0] = 32'h55;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || out_channel !== 2'd0) begin
      n_fail++; $display("FAIL midrst_offer: valid=%0b ch%0d want 1 ch0", out_valid, out_channel);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || tx_count !== 32'd0 || pending !== 4'hF) begin
      n_fail++;
      $display("FAIL midrst_async: valid=%0b cnt=%0d pending=%b want 0/0/1111",
               out_valid, tx_count, pending);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    sb_q.push_back({2'd0, 32'h55});
    sb_q.push_back({2'd1, 32'd7});
    sb_q.push_back({2'd2, 32'hDEADBEEF});
    sb_q.push_back({2'd3, 32'hA3});
    for (int c = 0; c < 64 && sb_q.size() > 0; c++) begin
      if (out_valid && out_ready) begin
        exp_x = sb_q.pop_front(); n_tests++;
        if ({out_channel, out_data} !== exp_x) begin
          n_fail++;
          $display("FAIL midrst_resync: got ch%0d 0x%08h want ch%0d 0x%08h",
                   out_channel, out_data, exp_x[DW+:CW], exp_x[DW-1:0]);
        end
      end
      @(negedge clk); ch_force = '0;
    end
    n_tests++;
    if (sb_q.size() != 0 || tx_count !== 32'd4 || pending !== 4'h0) begin
      n_fail++;
      $display("FAIL midrst_count: left=%0d cnt=%0d pending=%b want 0/4/0000",
               sb_q.size(), tx_count, pending);
      sb_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_coalesce();
    test_rr_order();
    test_force_on_handshake();
    test_gap();
    test_reset_mid_send();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
